// File: rtl/spi_master_param.sv
// Parametrised SPI master: all four SPI modes, DATA_W-bit words, NUM_CS active-low selects,
// spi_clk half-period of CLK_DIV sclk cycles. Start/busy/done host handshake.
// Optional receive path: define SPI_MASTER_RX_EN for full duplex; otherwise rx_data is 0.
module spi_master_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_CS  = 3,
  parameter int unsigned CLK_DIV = 2,
  localparam int unsigned CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              start,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_W);

  typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [EdgeW-1:0]    edge_q, edge_d;
  logic                spi_clk_q, spi_clk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;

  logic                cs_valid;
  logic [NUM_CS-1:0]   cs_dec;
  logic                accept;
  logic                finish;
  logic                div_wrap;
  logic [EdgeW-1:0]    edge_num;
  logic                last_edge;
  logic                tog;
  logic                adv;

  // Bit presented first for a given order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Drop the bit just presented so the next one sits at the output end.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Decode of the request, divider wrap and edge classification.
  always_comb begin
    cs_valid  = (32'(cs_sel) < NUM_CS);
    cs_dec    = NUM_CS'(1) << cs_sel;
    accept    = (state_q == StIdle) && start && cs_valid;
    div_wrap  = (div_q == DivLast);
    finish    = (state_q == StTrail) && div_wrap;
    edge_num  = edge_q + 1'b1;
    last_edge = (edge_num == EdgeLast);
    // LEAD's wrap is edge 1; each XFER wrap is the next edge.
    tog       = div_wrap && ((state_q == StLead) || (state_q == StXfer));
    // CPHA=1 shifts on odd edges; CPHA=0 on even edges except the final one.
    adv       = tog && (cpha_q ? edge_num[0] : (!edge_num[0] && !last_edge));
  end

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    spi_clk_d = spi_clk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_sh_d   = tx_sh_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StLead;
          div_d     = '0;
          edge_d    = '0;
          cpol_d    = mode[1];
          cpha_d    = mode[0];
          lsb_d     = lsb_first;
          spi_clk_d = mode[1];
          cs_n_d    = ~cs_dec;
          busy_d    = 1'b1;
          if (!mode[0]) begin
            // CPHA=0: first bit must be on the line before the first (sampling) edge.
            mosi_d  = first_bit(tx_data, lsb_first);
            tx_sh_d = shift_out(tx_data, lsb_first);
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end
      StLead, StXfer: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          spi_clk_d = ~spi_clk_q;
          edge_d    = edge_num;
          if (state_q == StLead) begin
            state_d = StXfer;
          end else if (last_edge) begin
            state_d = StTrail;
          end
        end
        if (adv) begin
          mosi_d  = first_bit(tx_sh_q, lsb_q);
          tx_sh_d = shift_out(tx_sh_q, lsb_q);
        end
      end
      StTrail: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (finish) begin
          state_d = StIdle;
          cs_n_d  = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      edge_q    <= '0;
      spi_clk_q <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_sh_q   <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      spi_clk_q <= spi_clk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_sh_q   <= tx_sh_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic              smp;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  // Receive shift: sample on the edges opposite to the shift edges, in transmit bit order.
  always_comb begin
    smp       = tog && (cpha_q ? !edge_num[0] : edge_num[0]);
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    if (accept) begin
      rx_sh_d = '0;
    end else if (smp) begin
      rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
    end
    if (finish) begin
      rx_data_d = rx_sh_q;
    end
  end

  // Receive registers; a reset discards any partial word.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

  assign spi_clk = spi_clk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: a default instance (8-bit, CLK_DIV=2) and a
// 16-bit CLK_DIV=1 instance for back-to-back transfers, driven against a behavioural SPI slave.
module tb_spi_master_param;

  localparam int unsigned WA   = 8;
  localparam int unsigned WB   = 16;
  localparam int unsigned NCS  = 3;
  localparam int unsigned DIVA = 2;
  localparam int unsigned DIVB = 1;

  logic sclk = 1'b0;
  logic reset;
  logic miso = 1'b0;
  always #5 sclk = ~sclk;

  logic          a_start, a_lsb, a_busy, a_done, a_spi_clk, a_mosi;
  logic [1:0]    a_cs_sel, a_mode;
  logic [WA-1:0] a_tx, a_rx;
  logic [NCS-1:0] a_cs_n;

  logic          b_start, b_lsb, b_busy, b_done, b_spi_clk, b_mosi;
  logic [1:0]    b_cs_sel, b_mode;
  logic [WB-1:0] b_tx, b_rx;
  logic [NCS-1:0] b_cs_n;

  spi_master_param #(.DATA_W(WA), .NUM_CS(NCS), .CLK_DIV(DIVA)) u_dut_a (
    .sclk(sclk), .reset(reset), .start(a_start), .cs_sel(a_cs_sel), .mode(a_mode),
    .lsb_first(a_lsb), .tx_data(a_tx), .rx_data(a_rx), .busy(a_busy), .done(a_done),
    .spi_clk(a_spi_clk), .mosi(a_mosi), .miso(miso), .cs_n(a_cs_n)
  );

  spi_master_param #(.DATA_W(WB), .NUM_CS(NCS), .CLK_DIV(DIVB)) u_dut_b (
    .sclk(sclk), .reset(reset), .start(b_start), .cs_sel(b_cs_sel), .mode(b_mode),
    .lsb_first(b_lsb), .tx_data(b_tx), .rx_data(b_rx), .busy(b_busy), .done(b_done),
    .spi_clk(b_spi_clk), .mosi(b_mosi), .miso(miso), .cs_n(b_cs_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // i-th bit on the wire for a word sent in the given order.
  function automatic logic order_bit(input logic [31:0] w, input int n, input logic lsb,
                                     input int i);
    return lsb ? w[i] : w[n-1-i];
  endfunction

  function automatic logic [31:0] seq_of(input logic [31:0] w, input int n, input logic lsb);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s[i] = order_bit(w, n, lsb, i);
    return s;
  endfunction

  function automatic logic [31:0] exp_rx(input logic [31:0] w);
`ifdef SPI_MASTER_RX_EN
    return w;
`else
    return 32'h0 & w;
`endif
  endfunction

  // Behavioural slave: samples on rising spi_clk iff CPOL==CPHA, shifts on the other edge.
  logic        use_b = 1'b0;
  logic        m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  int          m_w = WA;
  logic [31:0] slv_word = '0;
  int          slv_idx = 0;
  logic [31:0] mon_seq = '0;
  int          mon_bits = 0;
  int          edges = 0;
  logic        clk_prev = 1'b0, act_prev = 1'b0;
  logic        m_clk, m_mosi, m_act;

  assign m_clk  = use_b ? b_spi_clk : a_spi_clk;
  assign m_mosi = use_b ? b_mosi : a_mosi;
  assign m_act  = use_b ? (b_cs_n != '1) : (a_cs_n != '1);

  always @(negedge sclk) begin
    clk_prev <= m_clk;
    act_prev <= m_act;
    if (m_act && !act_prev) begin
      mon_bits <= 0;
      mon_seq  <= '0;
      edges    <= 0;
      if (!m_cpha) begin
        miso    <= order_bit(slv_word, m_w, m_lsb, 0);
        slv_idx <= 1;
      end else begin
        slv_idx <= 0;
      end
    end else if (m_act && (m_clk != clk_prev)) begin
      edges <= edges + 1;
      if (m_clk == (m_cpol == m_cpha)) begin
        mon_seq[mon_bits] <= m_mosi;
        mon_bits <= mon_bits + 1;
      end else if (slv_idx < m_w) begin
        miso    <= order_bit(slv_word, m_w, m_lsb, slv_idx);
        slv_idx <= slv_idx + 1;
      end
    end
  end

  int a_dones = 0;
  always @(negedge sclk) if (a_done === 1'b1) a_dones <= a_dones + 1;

  task automatic begin_a(input logic [7:0] tx, input logic [1:0] md, input logic lsb,
                         input logic [1:0] sel, input logic [7:0] sw);
    logic [2:0] exp_cs;
    use_b = 1'b0; m_cpol = md[1]; m_cpha = md[0]; m_lsb = lsb; m_w = WA;
    slv_word = {24'h0, sw};
    a_tx = tx; a_mode = md; a_lsb = lsb; a_cs_sel = sel; a_start = 1'b1;
    @(posedge sclk); #1;
    a_start = 1'b0;
    // Latched values must not follow the inputs any more.
    a_tx = WA'($urandom); a_mode = 2'($urandom); a_lsb = 1'($urandom);
    exp_cs = ~(3'b001 << sel);
    check("busy_on", a_busy, 1);
    check("cs_sel", a_cs_n, exp_cs);
  endtask

  task automatic xfer_a(input logic [7:0] tx, input logic [1:0] md, input logic lsb,
                        input logic [1:0] sel, input logic [7:0] sw, input bit poke);
    int cyc = 0;
    int d0 = a_dones;
    begin_a(tx, md, lsb, sel, sw);
    while (a_done !== 1'b1 && cyc < 100) begin
      if (poke && cyc == 9) begin
        a_start = 1'b1; a_cs_sel = 2'd0;
      end else begin
        a_start = 1'b0;
      end
      @(posedge sclk); #1;
      cyc++;
    end
    check("done_lat", cyc, (2 * WA + 1) * DIVA);
    check("rx_data", a_rx, exp_rx({24'h0, sw}));
    check("mosi_seq", mon_seq, seq_of({24'h0, tx}, WA, lsb));
    check("edges", edges, 2 * WA);
    check("busy_off", a_busy, 0);
    check("cs_idle", a_cs_n, 3'b111);
    check("clk_idle", a_spi_clk, md[1]);
    @(posedge sclk); #1;
    check("done_width", a_done, 0);
    check("one_done", a_dones - d0, 1);
    if (poke) begin
      repeat (40) @(posedge sclk);
      #1;
      check("poke_ignored", a_dones - d0, 1);
      check("poke_busy", a_busy, 0);
    end
  endtask

  initial begin
    int cyc;
    int d0;
    reset = 1'b1;
    a_start = 0; a_cs_sel = 0; a_mode = 0; a_lsb = 0; a_tx = 0;
    b_start = 0; b_cs_sel = 0; b_mode = 0; b_lsb = 0; b_tx = 0;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_cs_n", a_cs_n, 3'b111);
    check("rst_spi_clk", a_spi_clk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_rx", a_rx, 0);
    reset = 1'b0;
    @(posedge sclk); #1;

    xfer_a(8'hA5, 2'd0, 1'b0, 2'd0, 8'h3C, 1'b0);
    xfer_a(8'h81, 2'd3, 1'b1, 2'd1, 8'h5A, 1'b0);

    // Out-of-range select is ignored.
    a_cs_sel = 2'd3; a_start = 1'b1;
    @(posedge sclk); #1;
    a_start = 1'b0;
    check("bad_sel_busy", a_busy, 0);
    check("bad_sel_cs", a_cs_n, 3'b111);
    repeat (4) @(posedge sclk);
    #1;
    check("bad_sel_busy2", a_busy, 0);
    check("bad_sel_cs2", a_cs_n, 3'b111);

    xfer_a(8'h6E, 2'd2, 1'b0, 2'd2, 8'h93, 1'b1);

    // Reset in the middle of a mode-3 transfer.
    d0 = a_dones;
    begin_a(8'hC3, 2'd3, 1'b0, 2'd2, 8'h77);
    repeat (19) @(posedge sclk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_cs", a_cs_n, 3'b111);
    check("mid_rst_clk", a_spi_clk, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_rx", a_rx, 0);
    check("mid_rst_done", a_done, 0);
    @(posedge sclk); #1;
    reset = 1'b0;
    repeat (40) @(posedge sclk);
    #1;
    check("mid_rst_no_done", a_dones - d0, 0);
    xfer_a(8'h3D, 2'd1, 1'b1, 2'd0, 8'hE4, 1'b0);

    for (int i = 0; i < 12; i++) begin
      xfer_a(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom_range(0, 2)),
             8'($urandom), 1'b0);
    end

    // Back-to-back on the 16-bit instance, start held high, loopback-style slave.
    use_b = 1'b1; m_cpol = 1'b0; m_cpha = 1'b1; m_lsb = 1'b0; m_w = WB;
    slv_word = 32'hBEEF;
    b_mode = 2'd1; b_lsb = 1'b0; b_cs_sel = 2'd2; b_tx = 16'hBEEF; b_start = 1'b1;
    @(posedge sclk); #1;
    check("b_busy1", b_busy, 1);
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 100) begin
      @(posedge sclk); #1;
      cyc++;
    end
    check("b_lat1", cyc, (2 * WB + 1) * DIVB);
    check("b_rx1", b_rx, exp_rx(32'hBEEF));
    check("b_seq1", mon_seq, seq_of(32'hBEEF, WB, 1'b0));
    check("b_cs_gap", b_cs_n, 3'b111);
    b_tx = 16'h1234;
    slv_word = 32'h1234;
    @(posedge sclk); #1;
    b_start = 1'b0;
    check("b_cs_lo", b_cs_n, 3'b011);
    check("b_busy2", b_busy, 1);
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 100) begin
      @(posedge sclk); #1;
      cyc++;
    end
    check("b_lat2", cyc + 1, 2 * WB + 2);
    check("b_rx2", b_rx, exp_rx(32'h1234));
    check("b_seq2", mon_seq, seq_of(32'h1234, WB, 1'b0));
    @(posedge sclk); #1;
    check("b_idle", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master for the serial-interface subsystem. It supports all four SPI modes, a configurable word width, a configurable number of chip selects and a programmable serial-clock divider. The system clock `sclk` drives the block, and the block generates its own `spi_clk` toward the slaves. It sits between a register/host interface, which uses a start/busy/done handshake, and up to `NUM_CS` slave devices.

## Interface
Parameters:
- `DATA_W`, default 8: bits per transfer; legal range 2–32.
- `NUM_CS`, default 3: number of slave selects; legal range 1–8.
- `CLK_DIV`, default 2: `sclk` cycles per `spi_clk` half-period; must be ≥1.

Ports (CSW = max(1, clog2(NUM_CS))):
- `sclk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: transfer request; sampled only in IDLE.
- `cs_sel` in CSW: target slave index, 0..NUM_CS-1.
- `mode` in 2: {CPOL, CPHA}.
- `lsb_first` in 1: 1 = LSB shifted first; 0 = MSB first.
- `tx_data` in DATA_W: word to transmit.
- `rx_data` out DATA_W: last received word; holds until the next `done`.
- `busy` out 1: high while a transfer is in progress.
- `done` out 1: one-cycle pulse at transfer end.
- `spi_clk` out 1: serial clock.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.
- `cs_n` out NUM_CS: active-low selects, one-hot-low.

## Operation
- Reset values: `busy`=0, `done`=0, `cs_n`=all 1, `spi_clk`=0, `mosi`=0, `rx_data`=0, state IDLE.
- Reset mid-transfer:
  - All outputs return to reset values immediately, asynchronously.
  - No `done` pulse is produced.
  - The partial `rx_data` is discarded.
- **IDLE**
  - `spi_clk` = CPOL of the last latched mode (0 after reset); `cs_n` all 1.
  - On `start`=1 with `cs_sel` < NUM_CS, the block latches `tx_data`, `mode`, `lsb_first` and `cs_sel`, then goes to LEAD.
  - `start` with `cs_sel` ≥ NUM_CS is ignored: no state change, no `done`.
- **LEAD** (CLK_DIV cycles)
  - `cs_n[sel]`=0, `busy`=1, `spi_clk`=CPOL.
  - If CPHA=0, `mosi` presents the first bit on LEAD entry.
- **TRANSFER** (2·DATA_W half-periods)
  - A divider counter counts 0..CLK_DIV-1; `spi_clk` toggles on its wrap. Edges are numbered 1..2·DATA_W.
  - CPHA=0: `miso` is sampled on odd edges; `mosi` advances on even edges 2..2W-2.
  - CPHA=1: `mosi` advances on odd edges (bit 0 on edge 1); `miso` is sampled on even edges.
  - A sample captures the `miso` value registered at the same `sclk` edge that toggles `spi_clk`.
  - The receive shift direction follows `lsb_first`, so that `rx_data` bit order matches the transmit bit order.
  - After edge 2W, `spi_clk`=CPOL and the block goes to TRAIL.
- **TRAIL** (CLK_DIV cycles)
  - `cs_n` stays low and `mosi` holds its last bit.
  - At TRAIL end, the block updates `rx_data`, raises `cs_n`, pulses `done`, clears `busy` and returns to IDLE — all on the same edge.
- **Handshake**
  - `start` while `busy`=1 is ignored.
  - `start` in the cycle `done`=1 is accepted, because `busy` is already 0. This gives back-to-back transfers with `cs_n` high for ≥1 cycle between them.
- Inputs other than `miso` are don't-care after latching.

## Timing
- `start` sampled at edge 0 → `busy`=1 and `cs_n[sel]`=0 at edge 1.
- `spi_clk` toggles at edges 1+k·CLK_DIV, for k=1..2·DATA_W.
- `done`=1, `busy`=0 and `cs_n` rise at edge 1+(2·DATA_W+1)·CLK_DIV.
  - Defaults: toggles at edges 3,5,…,33; `done` at edge 35.
- `cs_n`-to-first-`spi_clk` setup and last-edge-to-`cs_n` hold are each CLK_DIV `sclk` cycles.
- `rx_data` is valid from the `done` edge onward.

## Configuration
- `SPI_MASTER_RX_EN` defined: full duplex; receive shift register and `rx_data` behave as above.
- Not defined:
  - The receive path is removed; `miso` is ignored and `rx_data` is constant 0.
  - Transmit, `cs_n`, `spi_clk`, `busy` and `done` timing are identical.

## Test plan
- **Mode 0, MSB first** (defaults, RX_EN defined): `tx_data`=8'hA5, slave model returns 8'h3C.
  - `mosi` sequence 1,0,1,0,0,1,0,1.
  - `rx_data`=8'h3C at edge 35; `done` high for exactly 1 cycle.
  - `spi_clk` idles at 0.
- **Mode 3, LSB first:** `tx_data`=8'h81, slave returns 8'h5A LSB-first.
  - `spi_clk` idles at 1; `mosi` sequence 1,0,0,0,0,0,0,1.
  - `rx_data`=8'h5A.
- **Invalid select / start while busy:**
  - `cs_sel`=3 with NUM_CS=3 → no `cs_n` activity, `busy` stays 0.
  - Second `start` pulse at edge 10 of a running transfer → exactly one `done`.
- **Reset mid-transfer:** `reset` asserted at edge 20 → immediately `cs_n`=3'b111, `spi_clk`=0, `busy`=0, `rx_data`=0; no `done`. A new transfer after reset completes normally.
- **Back-to-back, DATA_W=16, CLK_DIV=1, mode 1:** `start` held high.
  - Transfers 16'hBEEF then 16'h1234.
  - `done` at edges 34 and 68; `cs_n` high for 1 cycle between transfers.
  - Both words looped back correctly.
